// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: owns the fetch PC, chooses redirect / predicted /
// sequential next address and registers each accepted fetch into the IF->ID slot.
module fetch_pc_gen #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1c000000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  icReady,
  input  logic                  exVld,
  input  logic                  exWrong,
  input  logic [ADDR_WIDTH-1:0] exTarget,
  input  logic                  pdBranch,
  input  logic [ADDR_WIDTH-1:0] pdPC,
  input  logic                  pdReason,
  output logic                  ifVld,
  output logic [ADDR_WIDTH-1:0] ifPC,
  output logic                  idVld,
  output logic [ADDR_WIDTH-1:0] idPC,
  output logic [1:0]            idMask,
  output logic                  idPdBranch,
  output logic [ADDR_WIDTH-1:0] idPdPC,
  output logic                  idAdef,
  output logic                  flush
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    flush_q, flush_d;
  logic                    id_vld_q, id_vld_d;
  logic [ADDR_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [1:0]              id_mask_q, id_mask_d;
  logic                    id_pdb_q, id_pdb_d;
  logic [ADDR_WIDTH-1:0]   id_pdpc_q, id_pdpc_d;
  logic                    id_adef_q, id_adef_d;

  logic                    redirect;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   pc_pair;
  logic [ADDR_WIDTH-1:0]   pc_seq;

  assign redirect = exVld & exWrong;
  assign ifVld    = (state_q != BOOT);
  assign accept   = ifVld & icReady & ~stall & ~redirect;
  assign pc_pair  = {pc_q[ADDR_WIDTH-1:3], 3'b000};
  assign pc_seq   = pc_pair + ADDR_WIDTH'(8);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect)                state_d = RUN;
        else if (stall || !icReady)  state_d = HOLD;
      end
      HOLD: begin
        if (redirect || (!stall && icReady)) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    flush_d = redirect;
    if (redirect)      pc_d = exTarget;
    else if (!accept)  pc_d = pc_q;
    else if (pdBranch) pc_d = pdPC;
    else               pc_d = pc_seq;
  end

  // A redirect kills the slot even while stalled; otherwise stall freezes every field.
  always_comb begin
    id_vld_d  = id_vld_q;
    id_pc_d   = id_pc_q;
    id_mask_d = id_mask_q;
    id_pdb_d  = id_pdb_q;
    id_pdpc_d = id_pdpc_q;
    id_adef_d = id_adef_q;
    if (redirect) begin
      id_vld_d  = 1'b0;
      id_mask_d = 2'b00;
    end else if (stall) begin
      id_vld_d  = id_vld_q;
    end else if (accept) begin
      id_vld_d     = 1'b1;
      id_pc_d      = pc_pair;
      id_mask_d[0] = ~pc_q[2];
      id_mask_d[1] = ~(pdBranch & ~pdReason & ~pc_q[2]);
      id_pdb_d     = pdBranch;
      id_pdpc_d    = pdPC;
      id_adef_d    = |pc_q[1:0];
    end else begin
      id_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      flush_q   <= 1'b0;
      id_vld_q  <= 1'b0;
      id_pc_q   <= '0;
      id_mask_q <= '0;
      id_pdb_q  <= 1'b0;
      id_pdpc_q <= '0;
      id_adef_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flush_q   <= flush_d;
      id_vld_q  <= id_vld_d;
      id_pc_q   <= id_pc_d;
      id_mask_q <= id_mask_d;
      id_pdb_q  <= id_pdb_d;
      id_pdpc_q <= id_pdpc_d;
      id_adef_q <= id_adef_d;
    end
  end

  assign ifPC       = pc_q;
  assign flush      = flush_q;
  assign idVld      = id_vld_q;
  assign idPC       = id_pc_q;
  assign idMask     = id_mask_q;
  assign idPdBranch = id_pdb_q;
  assign idPdPC     = id_pdpc_q;
  assign idAdef     = id_adef_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: stimulus pushes expected ID slots into a queue,
// a monitor pops and compares whenever idVld is presented.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, icReady, exVld, exWrong, pdBranch, pdReason;
  logic [31:0] exTarget, pdPC;
  logic        ifVld, idVld, idPdBranch, idAdef, flush;
  logic [31:0] ifPC, idPC, idPdPC;
  logic [1:0]  idMask;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic        pdb;
    logic [31:0] pdpc;
    logic        adef;
  } id_t;

  id_t exp_q[$];

  fetch_pc_gen #(.ADDR_WIDTH(32), .RESET_PC(32'h1c000000)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .icReady(icReady),
    .exVld(exVld), .exWrong(exWrong), .exTarget(exTarget),
    .pdBranch(pdBranch), .pdPC(pdPC), .pdReason(pdReason),
    .ifVld(ifVld), .ifPC(ifPC), .idVld(idVld), .idPC(idPC), .idMask(idMask),
    .idPdBranch(idPdBranch), .idPdPC(idPdPC), .idAdef(idAdef), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] mask, input logic pdb,
                      input logic [31:0] pdpc, input logic adef);
    id_t e;
    e.pc = pc; e.mask = mask; e.pdb = pdb; e.pdpc = pdpc; e.adef = adef;
    exp_q.push_back(e);
  endtask

  task automatic redir(input logic [31:0] tgt);
    exVld = 1'b1; exWrong = 1'b1; exTarget = tgt;
  endtask

  task automatic no_redir();
    exVld = 1'b0; exWrong = 1'b0; exTarget = '0;
  endtask

  task automatic pd(input logic b, input logic r, input logic [31:0] tgt);
    pdBranch = b; pdReason = r; pdPC = tgt;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    id_t e;
    forever begin
      @(posedge clk);
      #1;
      if (idVld === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_idVld", 32'(idVld), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("idPC",       idPC,             e.pc);
          chk("idMask",     32'(idMask),      32'(e.mask));
          chk("idPdBranch", 32'(idPdBranch),  32'(e.pdb));
          chk("idPdPC",     idPdPC,           e.pdpc);
          chk("idAdef",     32'(idAdef),      32'(e.adef));
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; stall = 1'b0; icReady = 1'b1;
    no_redir();
    pd(1'b0, 1'b0, 32'h0);
    repeat (2) tick();

    // T1 reset values and boot sequence
    chk("rst_ifVld",  32'(ifVld),  32'd0);
    chk("rst_ifPC",   ifPC,        32'h1c000000);
    chk("rst_idVld",  32'(idVld),  32'd0);
    chk("rst_idMask", 32'(idMask), 32'd0);
    chk("rst_idPdB",  32'(idPdBranch), 32'd0);
    chk("rst_idPdPC", idPdPC,      32'd0);
    chk("rst_idAdef", 32'(idAdef), 32'd0);
    chk("rst_flush",  32'(flush),  32'd0);
    rstn = 1'b1;
    #1 chk("boot_ifVld", 32'(ifVld), 32'd0);
    tick();
    chk("c2_ifVld", 32'(ifVld), 32'd1);
    chk("c2_ifPC",  ifPC,       32'h1c000000);
    chk("c2_idVld", 32'(idVld), 32'd0);
    push(32'h1c000000, 2'b11, 1'b0, 32'h0, 1'b0);
    tick();
    chk("c3_ifPC", ifPC, 32'h1c000008);

    // T2 lower-instruction predicted taken
    redir(32'h1c000010);
    tick();
    chk("t2_redir_ifPC", ifPC, 32'h1c000010);
    chk("t2_flush",      32'(flush), 32'd1);
    chk("t2_idVld",      32'(idVld), 32'd0);
    no_redir();
    pd(1'b1, 1'b0, 32'h1c000100);
    push(32'h1c000010, 2'b01, 1'b1, 32'h1c000100, 1'b0);
    tick();
    chk("t2_ifPC",  ifPC,        32'h1c000100);
    chk("t2_flush0", 32'(flush), 32'd0);
    pd(1'b0, 1'b0, 32'h0);

    // T3 unaligned pair entry
    redir(32'h1c000104);
    tick();
    chk("t3_redir_ifPC", ifPC, 32'h1c000104);
    no_redir();
    push(32'h1c000100, 2'b10, 1'b0, 32'h0, 1'b0);
    tick();
    chk("t3_ifPC", ifPC, 32'h1c000108);

    // T4 stall freezes PC and slot, then icReady low drops idVld
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(32'h1c000100, 2'b10, 1'b0, 32'h0, 1'b0);
      tick();
      chk("t4_stall_ifPC", ifPC, 32'h1c000108);
    end
    stall = 1'b0; icReady = 1'b0;
    tick();
    chk("t4_nrdy_idVld", 32'(idVld), 32'd0);
    chk("t4_nrdy_ifPC",  ifPC,       32'h1c000108);
    icReady = 1'b1;
    push(32'h1c000108, 2'b11, 1'b0, 32'h0, 1'b0);
    tick();
    chk("t4_resume_ifPC", ifPC, 32'h1c000110);

    // T5 redirect while stalled
    stall = 1'b1;
    redir(32'h1c000200);
    tick();
    chk("t5_ifPC",   ifPC,        32'h1c000200);
    chk("t5_flush",  32'(flush),  32'd1);
    chk("t5_idVld",  32'(idVld),  32'd0);
    chk("t5_idMask", 32'(idMask), 32'd0);
    no_redir();
    tick();
    chk("t5_hold_ifPC", ifPC,       32'h1c000200);
    chk("t5_flush0",    32'(flush), 32'd0);
    chk("t5_hold_idVld", 32'(idVld), 32'd0);
    stall = 1'b0;

    // T6 address wrap and misaligned fetch
    redir(32'hfffffff8);
    tick();
    chk("t6_ifPC_top", ifPC, 32'hfffffff8);
    no_redir();
    push(32'hfffffff8, 2'b11, 1'b0, 32'h0, 1'b0);
    tick();
    chk("t6_wrap_ifPC", ifPC, 32'h0);
    redir(32'h1c000002);
    tick();
    chk("t6_adef_ifPC", ifPC, 32'h1c000002);
    no_redir();
    push(32'h1c000000, 2'b11, 1'b0, 32'h0, 1'b1);
    tick();
    chk("t6_adef_next", ifPC, 32'h1c000008);

    // Upper-instruction prediction keeps both slots
    pd(1'b1, 1'b1, 32'h1c000300);
    push(32'h1c000008, 2'b11, 1'b1, 32'h1c000300, 1'b0);
    tick();
    chk("upr_ifPC", ifPC, 32'h1c000300);
    pd(1'b0, 1'b0, 32'h0);
    icReady = 1'b0;
    tick();
    chk("upr_drain_idVld", 32'(idVld), 32'd0);
    icReady = 1'b1;

    // Mid-run reset is immediate, then redirect in BOOT
    rstn = 1'b0;
    #1;
    chk("mrst_ifVld", 32'(ifVld), 32'd0);
    chk("mrst_ifPC",  ifPC,       32'h1c000000);
    chk("mrst_idVld", 32'(idVld), 32'd0);
    rstn = 1'b1;
    redir(32'h1c000400);
    tick();
    chk("boot_redir_ifPC",  ifPC,       32'h1c000400);
    chk("boot_redir_ifVld", 32'(ifVld), 32'd1);
    chk("boot_redir_flush", 32'(flush), 32'd1);
    no_redir();
    push(32'h1c000400, 2'b11, 1'b0, 32'h0, 1'b0);
    tick();
    chk("boot_redir_next", ifPC, 32'h1c000408);
    icReady = 1'b0;
    repeat (2) tick();

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
